clkgen_multich: RTL
===================

Name: clkgen_multich

Overview:
Parametrised, fully synchronous successor to the single-output pixel-clock PLL wrapper. It generates NUM_CH independent fractional-frequency clock enables from one reference clock using phase accumulators (DDS style), so VGA, audio and other timing can share one clock domain. Each channel's frequency and phase can be reprogrammed at runtime. A PLL-style lock indicator reports when the outputs are stable and phase-aligned.

Parameters:
- NUM_CH, 4, number of output channels (1..16).
- ACC_W, 24, accumulator width. Channel frequency = f_refclk * inc / 2^ACC_W.
- LOCK_CYCLES, 16, settle cycles before locked asserts (>=1).
- DEFAULT_INC, 2^(ACC_W-2), reset increment loaded into every channel.
- CH_W, $clog2(NUM_CH) (min 1), width of the channel select.

Ports:
- refclk  in  1  single system/reference clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- cfg_we  in  1  config write strobe, one cycle.
- cfg_ch  in  CH_W  channel index for the write.
- cfg_inc  in  ACC_W  new frequency increment.
- cfg_phase  in  ACC_W  new phase offset, loaded into the accumulator at alignment.
- cfg_err  out  1  one-cycle pulse when a write has cfg_ch >= NUM_CH.
- outclk_en  out  NUM_CH  per-channel one-cycle clock-enable pulse (accumulator carry).
- outclk_sq  out  NUM_CH  per-channel square wave (accumulator MSB).
- locked  out  1  outputs stable and aligned.

Behaviour:
- Reset (rst high at an edge):
  - state=S_RST; locked=0, outclk_en=0, outclk_sq=0, cfg_err=0.
  - All acc=0; shadow inc[c]=DEFAULT_INC; shadow phase[c]=0; settle counter=0.
  - Reset asserted mid-operation has the same effect and overrides cfg_we in the same cycle.
- FSM, one transition per edge:
  - S_RST -> S_ALIGN on the first edge with rst low.
  - S_ALIGN: acc[c]<=phase[c] for every channel, counter<=0, outputs 0; then -> S_SETTLE.
  - S_SETTLE: accumulators run; counter increments each cycle. When counter==LOCK_CYCLES-1, go to S_LOCKED and set locked<=1 on that same edge. locked therefore rises on the (LOCK_CYCLES+2)th edge after rst deasserts.
  - S_LOCKED: accumulators run, locked=1.
- Accumulator update (S_SETTLE/S_LOCKED), each cycle, per channel:
  - {carry, acc[c]} <= acc[c] + inc[c] (ACC_W+1-bit sum); acc wraps modulo 2^ACC_W.
  - outclk_en[c] <= carry, registered on the same edge. The pulse is visible in the cycle after the overflowing add.
  - outclk_sq[c] <= MSB of the new acc[c].
- Disabled channel: inc[c]==0 gives no pulses, and outclk_sq holds the MSB of phase[c].
- Full rate: inc = 2^ACC_W-1 gives outclk_en high on all but every 2^ACC_W-th cycle. There is no saturation.
- Config writes:
  - cfg_we with valid cfg_ch, in any non-reset state: on that edge, inc[cfg_ch]<=cfg_inc and phase[cfg_ch]<=cfg_phase.
  - If the state was S_SETTLE or S_LOCKED, the next state is S_ALIGN. locked drops to 0 on the same edge, and all channels realign (global phase coherence).
  - A write during S_ALIGN updates the shadows, which are used in that alignment cycle's successor; state still goes to S_SETTLE.
  - Back-to-back writes each restart alignment; locked stays low until LOCK_CYCLES after the last write.
- Invalid cfg_ch (>= NUM_CH): write ignored, state unchanged, cfg_err=1 for exactly one cycle.
- Multiple cfg_we cycles are independent; there is no handshake and the block always accepts.

Optional Feature:
CLKGEN_OUTPUT_GATE_EN:
- Defined: outclk_en and outclk_sq are forced to 0 whenever locked=0, so downstream logic never sees unaligned edges.
- Undefined: outputs follow the accumulators during S_SETTLE as well. They are still 0 in S_RST and S_ALIGN.

Test Plan:
- ACC_W=8, LOCK_CYCLES=4, release rst -> locked rises exactly 6 edges later; all outputs 0 before S_SETTLE; default inc=64 gives outclk_en pulses every 4 cycles.
- Write ch1 inc=128 phase=0 while locked -> locked falls the next cycle and relocks after 6 cycles; ch1 outclk_sq is a 50% square of period 2; outclk_en pulses every 2 cycles.
- Ch0 inc=64 phase=0, ch2 inc=64 phase=128 -> ch2 outclk_en pulses lead ch0 by 2 cycles, same period 4.
- Write ch3 inc=0 -> ch3 outclk_en stays 0 over 1000 cycles; other channels unaffected.
- cfg_we with cfg_ch=5 when NUM_CH=4 -> cfg_err pulses 1 cycle; locked stays 1; no channel changes.
- Assert rst for 1 cycle while locked with cfg_we high -> all outputs 0 the next cycle; shadows back to DEFAULT_INC/0; the write is discarded; relock after LOCK_CYCLES+2 cycles.

Source files
------------

// File: rtl/clkgen_multich.sv
// clkgen_multich: NUM_CH independent DDS phase-accumulator clock enables sharing one reference clock.
// Latency: outputs are registered on the edge of the accumulating add; locked rises LOCK_CYCLES+2 edges after reset release.
// Backpressure: none, config writes are always accepted; a bad channel index gives a one-cycle cfg_err pulse.
// Optional build macro: CLKGEN_OUTPUT_GATE_EN forces outclk_en/outclk_sq to 0 whenever locked is low.
module clkgen_multich #(
    parameter int              NUM_CH      = 4,
    parameter int              ACC_W       = 24,
    parameter int              LOCK_CYCLES = 16,
    parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(1) << (ACC_W - 2),
    parameter int              CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] outclk_en,
    output logic [NUM_CH-1:0] outclk_sq,
    output logic              locked
);

    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_RST    = 2'd0,
        S_ALIGN  = 2'd1,
        S_SETTLE = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_locked;
    logic               r_cfg_err;
    logic [NUM_CH-1:0]  r_en;
    logic [NUM_CH-1:0]  r_sq;
    logic [ACC_W-1:0]   r_acc   [NUM_CH];
    logic [ACC_W-1:0]   r_inc   [NUM_CH];
    logic [ACC_W-1:0]   r_phase [NUM_CH];

    logic [ACC_W:0]     w_sum   [NUM_CH];
    logic               w_ch_valid;
    logic               w_wr_ok;
    logic               w_run;
    logic               w_lock_now;
    logic               w_out_open;

    assign w_ch_valid = (32'(cfg_ch) < NUM_CH);
    // Writes seen while still in S_RST are dropped; the block is not yet running.
    assign w_wr_ok    = cfg_we && w_ch_valid && (r_state != S_RST);
    assign w_run      = (r_state == S_SETTLE) || (r_state == S_LOCKED);
    assign w_lock_now = (r_state == S_SETTLE) && (r_cnt == CNT_W'(LOCK_CYCLES - 1)) && !w_wr_ok;

`ifdef CLKGEN_OUTPUT_GATE_EN
    // Outputs only pass when locked will be high after this edge.
    assign w_out_open = ((r_state == S_LOCKED) && !w_wr_ok) || w_lock_now;
`else
    assign w_out_open = w_run;
`endif

    // Per-channel (ACC_W+1)-bit sum; the top bit is the carry that forms the enable pulse.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_sum[c] = {1'b0, r_acc[c]} + {1'b0, r_inc[c]};
        end
    end

    // Control FSM, shadow config registers, accumulators and registered outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state   <= S_RST;
            r_cnt     <= '0;
            r_locked  <= 1'b0;
            r_cfg_err <= 1'b0;
            r_en      <= '0;
            r_sq      <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_acc[c]   <= '0;
                r_inc[c]   <= DEFAULT_INC;
                r_phase[c] <= '0;
            end
        end else begin
            r_cfg_err <= cfg_we && !w_ch_valid;

            for (int c = 0; c < NUM_CH; c++) begin
                if (w_wr_ok && (cfg_ch == CH_W'(c))) begin
                    r_inc[c]   <= cfg_inc;
                    r_phase[c] <= cfg_phase;
                end
                // A write landing on the alignment edge takes effect immediately.
                if (r_state == S_ALIGN) begin
                    r_acc[c] <= (w_wr_ok && (cfg_ch == CH_W'(c))) ? cfg_phase : r_phase[c];
                end else if (w_run) begin
                    r_acc[c] <= w_sum[c][ACC_W-1:0];
                end
                r_en[c] <= w_out_open & w_sum[c][ACC_W];
                r_sq[c] <= w_out_open & w_sum[c][ACC_W-1];
            end

            case (r_state)
                S_RST: begin
                    r_state  <= S_ALIGN;
                    r_locked <= 1'b0;
                end
                S_ALIGN: begin
                    r_state  <= S_SETTLE;
                    r_cnt    <= '0;
                    r_locked <= 1'b0;
                end
                S_SETTLE: begin
                    if (w_wr_ok) begin
                        r_state  <= S_ALIGN;
                        r_locked <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_lock_now) begin
                            r_state  <= S_LOCKED;
                            r_locked <= 1'b1;
                        end
                    end
                end
                S_LOCKED: begin
                    if (w_wr_ok) begin
                        r_state  <= S_ALIGN;
                        r_locked <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_RST;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_err   = r_cfg_err;
    assign outclk_en = r_en;
    assign outclk_sq = r_sq;
    assign locked    = r_locked;

endmodule
